// File: rtl/sprite_palette_pkg.sv
// -----------------------------------------------------------------------------
// sprite_palette_pkg
// Purpose : Shared types and constants for the sprite palette arbiter slice.
//           Holds the 12-bit RGB colour type, the transparency key and the
//           default palette applied to every sprite sheet.
// Contents: rgb12_t         {r,g,b} 4 bits each
//           KEY_INDEX       colour index treated as transparent
//           KEY_RGB         chroma key colour stored at KEY_INDEX
//           DEFAULT_PALETTE 16-entry default table
//           default_rgb()   default colour for any index
// -----------------------------------------------------------------------------
package sprite_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam int     KEY_INDEX = 0;
    localparam rgb12_t KEY_RGB   = 12'h6DF;

    // Entry 0 is the chroma key, entry 5 is black, everything else is white.
    localparam rgb12_t DEFAULT_PALETTE [0:15] = '{
        12'h6DF, 12'hFFF, 12'hFFF, 12'hFFF,
        12'hFFF, 12'h000, 12'hFFF, 12'hFFF,
        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
        12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF
    };

    // Indices beyond the 16-entry table (only possible with a wider IDX_W)
    // fall back to white so the lookup is always defined.
    function automatic rgb12_t default_rgb(input int unsigned idx);
        if (idx < 16)
            return DEFAULT_PALETTE[idx[3:0]];
        else
            return 12'hFFF;
    endfunction

endpackage

// File: rtl/sprite_palette_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purpose : Combinational round-robin arbiter. Picks the first asserted request
//           at or after the pointer, wrapping around, when enabled.
// Ports   : i_req          per-requester request
//           i_enable       grant allowed this cycle
//           i_pointer      highest-priority requester this cycle
//           o_grant        one-hot grant (all zero when nothing granted)
//           o_grant_id     index of the granted requester (0 when none)
//           o_grant_valid  a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_enable,
    input  logic [REQ_W-1:0]   i_pointer,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [REQ_W-1:0]   o_grant_id,
    output logic               o_grant_valid
);

    logic [REQ_W-1:0] w_cand;

    // Scan candidates in priority order starting at the pointer; the first
    // requester found wins and later candidates are ignored.
    always_comb begin
        o_grant       = '0;
        o_grant_id    = '0;
        o_grant_valid = 1'b0;
        w_cand        = '0;
        if (i_enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_cand = REQ_W'((int'(i_pointer) + k) % NUM_REQ);
                if (!o_grant_valid && i_req[w_cand]) begin
                    o_grant[w_cand] = 1'b1;
                    o_grant_id      = w_cand;
                    o_grant_valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_palette_arbiter
// Purpose : Shares one index->RGB sprite palette store among NUM_REQ pixel
//           requesters. One round-robin lookup per cycle lands in a single
//           registered response stage with backpressure. Index KEY_INDEX is
//           flagged as transparent.
// Config  : PALETTE_WRITE_EN defined   -> write port, palettes are registers
//           PALETTE_WRITE_EN undefined -> palettes are constant default ROM
// Ports   : Clk, Reset_n (async active-low)
//           req_valid/req_index/req_pal  packed per-requester lookup requests
//           req_ready                    one-hot grant
//           rsp_valid/rsp_ready          response handshake
//           rsp_id                       owner of the response
//           rsp_red/green/blue           looked-up colour
//           rsp_transparent              index was the key index
//           wr_en/wr_pal/wr_index/wr_rgb palette write (PALETTE_WRITE_EN only)
// -----------------------------------------------------------------------------
module sprite_palette_arbiter
    import sprite_palette_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_PAL = 4,
    parameter int IDX_W   = 4,
    parameter int REQ_W   = $clog2(NUM_REQ),
    parameter int PAL_W   = $clog2(NUM_PAL)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    input  logic [NUM_REQ*PAL_W-1:0] req_pal,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [REQ_W-1:0]         rsp_id,
    output logic [3:0]               rsp_red,
    output logic [3:0]               rsp_green,
    output logic [3:0]               rsp_blue,
    output logic                     rsp_transparent
`ifdef PALETTE_WRITE_EN
    ,
    input  logic                     wr_en,
    input  logic [PAL_W-1:0]         wr_pal,
    input  logic [IDX_W-1:0]         wr_index,
    input  logic [11:0]              wr_rgb
`endif
);

    // One bit wider than a palette select so NUM_PAL itself is representable.
    localparam logic [PAL_W:0] PAL_LIM = (PAL_W+1)'(NUM_PAL);

    logic             r_rsp_valid;
    logic [REQ_W-1:0] r_rsp_id;
    rgb12_t           r_rsp_rgb;
    logic             r_rsp_transp;
    logic [REQ_W-1:0] r_ptr;

    logic             w_can_load;
    logic [NUM_REQ-1:0] w_grant;
    logic [REQ_W-1:0] w_grant_id;
    logic             w_grant_valid;
    logic [IDX_W-1:0] w_sel_index;
    logic [PAL_W-1:0] w_sel_pal;
    logic             w_pal_ok;
    rgb12_t           w_lookup;
    logic             w_key_hit;
    logic [REQ_W-1:0] w_ptr_next;

    assign w_can_load = !r_rsp_valid || rsp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W)
    ) u_arb (
        .i_req         (req_valid),
        .i_enable      (w_can_load),
        .i_pointer     (r_ptr),
        .o_grant       (w_grant),
        .o_grant_id    (w_grant_id),
        .o_grant_valid (w_grant_valid)
    );

    assign req_ready = w_grant;

    // The grant is one-hot, so OR-ing the gated fields selects the winner.
    always_comb begin
        w_sel_index = '0;
        w_sel_pal   = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_grant[r]) begin
                w_sel_index |= req_index[r*IDX_W +: IDX_W];
                w_sel_pal   |= req_pal[r*PAL_W +: PAL_W];
            end
        end
    end

    assign w_pal_ok  = {1'b0, w_sel_pal} < PAL_LIM;
    assign w_key_hit = w_pal_ok && (w_sel_index == IDX_W'(KEY_INDEX));

`ifdef PALETTE_WRITE_EN
    rgb12_t r_palette [NUM_PAL][2**IDX_W];
    logic   w_wr_ok;

    assign w_wr_ok = {1'b0, wr_pal} < PAL_LIM;

    // Writable palettes: reset reloads the defaults. A write lands at the edge,
    // so a grant in the same cycle still reads the old entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < NUM_PAL; p++)
                for (int e = 0; e < 2**IDX_W; e++)
                    r_palette[p][e] <= default_rgb(e);
        end else if (wr_en && w_wr_ok) begin
            r_palette[wr_pal][wr_index] <= wr_rgb;
        end
    end

    assign w_lookup = w_pal_ok ? r_palette[w_sel_pal][w_sel_index] : '0;
`else
    // Every sheet shares the same constant default table.
    assign w_lookup = w_pal_ok ? default_rgb(int'(w_sel_index)) : '0;
`endif

    assign w_ptr_next = (w_grant_id == REQ_W'(NUM_REQ-1)) ? '0 : w_grant_id + 1'b1;

    // Response stage: reloads whenever it is empty or being drained. Data is
    // only replaced on a grant, so a drained stage keeps its last colour.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_rgb    <= '0;
            r_rsp_transp <= 1'b0;
            r_ptr        <= '0;
        end else if (w_can_load) begin
            r_rsp_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_rsp_id     <= w_grant_id;
                r_rsp_rgb    <= w_lookup;
                r_rsp_transp <= w_key_hit;
                r_ptr        <= w_ptr_next;
            end
        end
    end

    assign rsp_valid       = r_rsp_valid;
    assign rsp_id          = r_rsp_id;
    assign rsp_red         = r_rsp_rgb.r;
    assign rsp_green       = r_rsp_rgb.g;
    assign rsp_blue        = r_rsp_rgb.b;
    assign rsp_transparent = r_rsp_transp;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_palette_arbiter
// Purpose : Self-checking bench for sprite_palette_arbiter. Directed scenarios
//           followed by randomized traffic, all compared against a behavioural
//           model. NUM_PAL is 3 so a 2-bit palette select can be out of range.
//           Build with PALETTE_WRITE_EN to exercise the palette write port.
// -----------------------------------------------------------------------------
module tb_sprite_palette_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NUM_PAL = 3;
    localparam int IDX_W   = 4;
    localparam int REQ_W   = 2;
    localparam int PAL_W   = 2;

    logic                     clk = 1'b0;
    logic                     resetN;
    logic [NUM_REQ-1:0]       reqValid;
    logic [NUM_REQ*IDX_W-1:0] reqIndex;
    logic [NUM_REQ*PAL_W-1:0] reqPal;
    logic [NUM_REQ-1:0]       reqReady;
    logic                     rspValid;
    logic                     rspReady;
    logic [REQ_W-1:0]         rspId;
    logic [3:0]               rspRed, rspGreen, rspBlue;
    logic                     rspTransparent;
`ifdef PALETTE_WRITE_EN
    logic                     wrEn;
    logic [PAL_W-1:0]         wrPal;
    logic [IDX_W-1:0]         wrIndex;
    logic [11:0]              wrRgb;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state
    int mPtr;
    bit mRspValid;
    int mRspId;
    int mRspRgb;
    bit mRspTransp;
    int mPal [NUM_PAL][16];
    int lastGrant;

    sprite_palette_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_PAL (NUM_PAL),
        .IDX_W   (IDX_W)
    ) dut (
        .Clk             (clk),
        .Reset_n         (resetN),
        .req_valid       (reqValid),
        .req_index       (reqIndex),
        .req_pal         (reqPal),
        .req_ready       (reqReady),
        .rsp_valid       (rspValid),
        .rsp_ready       (rspReady),
        .rsp_id          (rspId),
        .rsp_red         (rspRed),
        .rsp_green       (rspGreen),
        .rsp_blue        (rspBlue),
        .rsp_transparent (rspTransparent)
`ifdef PALETTE_WRITE_EN
        ,
        .wr_en           (wrEn),
        .wr_pal          (wrPal),
        .wr_index        (wrIndex),
        .wr_rgb          (wrRgb)
`endif
    );

    // Free-running pixel clock
    always #5 clk = ~clk;

    // Counts one comparison and reports it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Model reset: empty response, pointer 0, default palettes everywhere
    task automatic resetModel();
        mPtr = 0; mRspValid = 0; mRspId = 0; mRspRgb = 0; mRspTransp = 0; lastGrant = -1;
        for (int p = 0; p < NUM_PAL; p++)
            for (int e = 0; e < 16; e++)
                mPal[p][e] = (e == 0) ? 'h6DF : (e == 5) ? 'h000 : 'hFFF;
    endtask

    // Which requester the rules say wins this cycle, or -1 for none
    function automatic int modelGrant();
        if (mRspValid && !rspReady) return -1;
        for (int k = 0; k < NUM_REQ; k++)
            if (reqValid[(mPtr + k) % NUM_REQ]) return (mPtr + k) % NUM_REQ;
        return -1;
    endfunction

    // Called at a falling edge with inputs already driven: checks the grant,
    // advances the model across the rising edge, checks the response.
    task automatic stepCycle(output int gid);
        logic [NUM_REQ-1:0] expReady;
        int idx, pal;
        gid = modelGrant();
        expReady = '0;
        if (gid >= 0) expReady[gid] = 1'b1;
        #1 checkOutput("req_ready", 32'(reqReady), 32'(expReady));
        @(posedge clk);
        if (!mRspValid || rspReady) begin
            mRspValid = (gid >= 0);
            if (gid >= 0) begin
                idx = int'(reqIndex[gid*IDX_W +: IDX_W]);
                pal = int'(reqPal[gid*PAL_W +: PAL_W]);
                mRspId     = gid;
                mRspRgb    = (pal < NUM_PAL) ? mPal[pal][idx] : 0;
                mRspTransp = (pal < NUM_PAL) && (idx == 0);
                mPtr       = (gid + 1) % NUM_REQ;
            end
        end
`ifdef PALETTE_WRITE_EN
        if (wrEn && int'(wrPal) < NUM_PAL) mPal[wrPal][wrIndex] = int'(wrRgb);
`endif
        lastGrant = gid;
        @(negedge clk);
        checkOutput("rsp_valid", 32'(rspValid), 32'(mRspValid));
        checkOutput("rsp_id", 32'(rspId), mRspId);
        checkOutput("rsp_rgb", 32'({rspRed, rspGreen, rspBlue}), mRspRgb);
        checkOutput("rsp_transparent", 32'(rspTransparent), 32'(mRspTransp));
    endtask

    // Random traffic; a requester still waiting keeps its request unchanged
    task automatic applyStimulus(input int validPct);
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!(reqValid[r] && lastGrant != r)) begin
                reqValid[r] = ($urandom_range(99) < validPct);
                reqIndex[r*IDX_W +: IDX_W] = IDX_W'($urandom_range(15));
                reqPal[r*PAL_W +: PAL_W]   = PAL_W'($urandom_range(3));
            end
        end
        rspReady = ($urandom_range(3) != 0);
`ifdef PALETTE_WRITE_EN
        wrEn    = ($urandom_range(3) == 0);
        wrPal   = PAL_W'($urandom_range(3));
        wrIndex = IDX_W'($urandom_range(15));
        wrRgb   = 12'($urandom_range(4095));
`endif
    endtask

    // Directed scenarios, then randomized traffic
    initial begin
        int g;
        logic [31:0] snap;
        resetN = 1'b0; reqValid = '0; reqIndex = '0; reqPal = '0; rspReady = 1'b0;
`ifdef PALETTE_WRITE_EN
        wrEn = 1'b0; wrPal = '0; wrIndex = '0; wrRgb = '0;
`endif
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rspValid), 0);
        checkOutput("reset_rsp_id", 32'(rspId), 0);
        checkOutput("reset_rsp_rgb", 32'({rspRed, rspGreen, rspBlue}), 0);
        checkOutput("reset_transparent", 32'(rspTransparent), 0);
        resetN = 1'b1;

        // Single request: index 5 on palette 1 is black, not transparent
        reqValid = 4'b0001; reqIndex[3:0] = 4'd5; reqPal[1:0] = 2'd1; rspReady = 1'b1;
        stepCycle(g);
        checkOutput("single_rsp", 32'({rspValid, rspId, rspRed, rspGreen, rspBlue, rspTransparent}),
                    32'({1'b1, 2'd0, 12'h000, 1'b0}));

        // All requesters valid: one grant per cycle in rotating order from 1
        reqValid = 4'hF;
        for (int r = 0; r < NUM_REQ; r++) begin
            reqIndex[r*IDX_W +: IDX_W] = IDX_W'($urandom_range(15));
            reqPal[r*PAL_W +: PAL_W]   = PAL_W'($urandom_range(2));
        end
        for (int i = 0; i < 8; i++) begin
            stepCycle(g);
            checkOutput("rr_order", 32'(rspId), (1 + i) % NUM_REQ);
            reqIndex[g*IDX_W +: IDX_W] = IDX_W'($urandom_range(15));
            reqPal[g*PAL_W +: PAL_W]   = PAL_W'($urandom_range(2));
        end

        // Backpressure: response held bit-exact, no grants, pointer frozen
        rspReady = 1'b0;
        snap = 32'({rspValid, rspId, rspRed, rspGreen, rspBlue, rspTransparent});
        for (int i = 0; i < 3; i++) begin
            stepCycle(g);
            checkOutput("stall_hold", 32'({rspValid, rspId, rspRed, rspGreen, rspBlue, rspTransparent}), snap);
            checkOutput("stall_ready", 32'(reqReady), 0);
        end
        rspReady = 1'b1;
        stepCycle(g);
        checkOutput("stall_release_id", 32'(rspId), 1);

        // Key index is transparent; out-of-range palette gives black, opaque
        reqValid = 4'b0100; reqIndex[11:8] = 4'd0; reqPal[5:4] = 2'd0;
        stepCycle(g);
        checkOutput("key_rgb", 32'({rspRed, rspGreen, rspBlue}), 32'h6DF);
        checkOutput("key_transparent", 32'(rspTransparent), 1);
        reqPal[5:4] = 2'd3;
        stepCycle(g);
        checkOutput("badpal_rgb", 32'({rspRed, rspGreen, rspBlue}), 0);
        checkOutput("badpal_transparent", 32'(rspTransparent), 0);

`ifdef PALETTE_WRITE_EN
        // Same-cycle write returns the old entry; the following grant sees it
        reqValid = 4'b0001; reqIndex[3:0] = 4'd3; reqPal[1:0] = 2'd0;
        wrEn = 1'b1; wrPal = 2'd0; wrIndex = 4'd3; wrRgb = 12'hF00;
        stepCycle(g);
        checkOutput("write_old", 32'({rspRed, rspGreen, rspBlue}), 32'hFFF);
        wrEn = 1'b0;
        stepCycle(g);
        checkOutput("write_new", 32'({rspRed, rspGreen, rspBlue}), 32'hF00);
`endif

        // Asynchronous reset while the response stage is full
        reqValid = 4'hF;
        stepCycle(g);
        checkOutput("pre_reset_valid", 32'(rspValid), 1);
        #2 resetN = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(rspValid), 0);
        checkOutput("async_reset_id", 32'(rspId), 0);
        checkOutput("async_reset_rgb", 32'({rspRed, rspGreen, rspBlue}), 0);
        resetModel();
        @(negedge clk);
        resetN = 1'b1;
        stepCycle(g);
        checkOutput("post_reset_ptr", 32'(rspId), 0);

        // Randomized traffic against the model
        repeat (400) begin
            applyStimulus(60);
            stepCycle(g);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
